// File: rtl/sonar_distance_display_pkg.sv
// Shared types, sizes and the 7-segment glyph table for the sonar distance display.
package sonar_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sonar_distance_display_if.sv
// Bundle between the ranging stage, the display block and the board pins.
interface sonar_distance_display_if #(
    parameter int W = 12
);
    import sonar_pkg::*;

    logic [W-1:0]     dist_in;
    logic             dist_valid;
    logic [6:0]       seg;
    logic [3:0]       an;
    logic [BCD_W-1:0] bcd_out;
    logic             bcd_valid;
    logic             busy;

    modport master (
        output dist_in, dist_valid,
        input  seg, an, bcd_out, bcd_valid, busy
    );

    modport slave (
        input  dist_in, dist_valid,
        output seg, an, bcd_out, bcd_valid, busy
    );

endinterface

// File: rtl/sonar_distance_display_bin2bcd.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, with a
// single-entry "latest value wins" pending slot for strobes arriving while busy.
module bin2bcd_seq
    import sonar_pkg::*;
#(
    parameter int W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     dist_in_i,
    input  logic             dist_valid_i,
    output logic [BCD_W-1:0] bcd_out_o,
    output logic             bcd_valid_o,
    output logic             busy_o
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    conv_state_t      state_q;
    logic [IW-1:0]    iter_q;
    logic [W-1:0]     bin_q;
    logic [BCD_W-1:0] acc_q;
    logic             pend_q;
    logic [W-1:0]     pend_val_q;
    logic [BCD_W-1:0] bcd_out_q;
    logic             bcd_valid_q;
    logic             busy_q;

    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] acc_d;
    logic [W-1:0]     bin_d;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                               : acc_q[gi*4 +: 4];
        end
    endgenerate

    // {bcd,bin} shifted left by one after the +3 correction.
    assign acc_d = {adj[BCD_W-2:0], bin_q[W-1]};
    assign bin_d = {bin_q[W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            bin_q       <= '0;
            acc_q       <= '0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dist_valid_i || pend_q) begin
                        // A live strobe beats a parked value; either way the slot empties.
                        bin_q   <= dist_valid_i ? dist_in_i : pend_val_q;
                        pend_q  <= 1'b0;
                        acc_q   <= '0;
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q  <= acc_d;
                    bin_q  <= bin_d;
                    iter_q <= iter_q + IW'(1);
                    if (iter_q == IW'(W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_out_q   <= acc_q;
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (state_q != IDLE && dist_valid_i) begin
                pend_q     <= 1'b1;
                pend_val_q <= dist_in_i;
            end
        end
    end

    assign bcd_out_o   = bcd_out_q;
    assign bcd_valid_o = bcd_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: rtl/sonar_distance_display.sv
// Distance-to-display stage: BCD conversion plus a multiplexed, leading-zero
// blanked 4-digit common-anode 7-segment driver.
module sonar_distance_display
    import sonar_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DIGIT_HZ = 1_000,
    parameter int W        = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    sonar_distance_display_if.slave     bus
);

    localparam int SCAN_DIV = CLK_HZ / DIGIT_HZ;
    localparam int CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [BCD_W-1:0] bcd_q;
    logic             bcd_valid_q;
    logic             busy_q;

    bin2bcd_seq #(.W(W)) u_bin2bcd (
        .clk          (clk),
        .rst          (rst),
        .dist_in_i    (bus.dist_in),
        .dist_valid_i (bus.dist_valid),
        .bcd_out_o    (bcd_q),
        .bcd_valid_o  (bcd_valid_q),
        .busy_o       (busy_q)
    );

    logic [CW-1:0] scan_cnt_q;
    logic [1:0]    digit_q;
    logic [1:0]    digit_d;
    logic [6:0]    seg_q;
    logic [6:0]    seg_d;
    logic [3:0]    an_q;
    logic [3:0]    an_d;
    logic          wrap;
    logic [6:0]    seg_digit [BCD_DIGITS];

    // Only the committed result is shown, so the display never flickers mid-conversion.
    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic blank;
            assign blank = (gi != 0) && ((bcd_q >> (4 * gi)) == '0);
            assign seg_digit[gi] = blank ? 7'h7F : seg_decode(bcd_q[gi*4 +: 4]);
        end
    endgenerate

    assign wrap = (scan_cnt_q == CW'(SCAN_DIV - 1));

    // seg/an follow the next digit index so they switch on the same edge, with no dark gap.
    always_comb begin
        digit_d = digit_q;
        if (wrap) begin
            digit_d = digit_q + 2'd1;
        end
        seg_d = seg_digit[digit_d];
        an_d  = ~(4'b0001 << digit_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 4'hF;
        end else begin
            scan_cnt_q <= wrap ? '0 : scan_cnt_q + CW'(1);
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sonar_distance_display.sv
// Directed bench for sonar_distance_display with a transaction-level reference model.
module tb_sonar_distance_display;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sonar_distance_display_if #(.W(12)) dif ();

    sonar_distance_display #(.CLK_HZ(4000), .DIGIT_HZ(1000), .W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int digit, input int val);
        int p;
        p = 1;
        for (int i = 0; i < digit; i++) p = p * 10;
        if (digit >= 1 && val < p) return 7'h7F;
        return glyph((val / p) % 10);
    endfunction

    // Reference model: a conversion accepted at edge s publishes its value at edge s+13;
    // strobes seen while a conversion is outstanding park the latest value.
    bit         armed = 0;
    int         edge_n = 0;
    int         n = 0;
    int         m_val = 0;
    logic       m_valid = 0;
    bit         act = 0;
    int         act_start = 0;
    int         conv_v = 0;
    bit         pend = 0;
    int         pend_v = 0;
    logic [6:0] m_seg = 7'h7F;
    logic [3:0] m_an = 4'hF;

    always begin
        logic r, dv;
        int   di, prev, digit;
        @(posedge clk);
        r  = rst;
        dv = dif.dist_valid;
        di = int'(dif.dist_in);
        edge_n++;
        if (r) begin
            armed = 1; n = 0; m_val = 0; m_valid = 0; act = 0; pend = 0;
            m_seg = 7'h7F; m_an = 4'hF;
        end else begin
            n++;
            prev    = m_val;
            m_valid = 0;
            if (act) begin
                if (dv) begin pend = 1; pend_v = di; end
                if (edge_n == act_start + 13) begin
                    m_val = conv_v; m_valid = 1; act = 0;
                end
            end else if (dv) begin
                act = 1; act_start = edge_n; conv_v = di; pend = 0;
            end else if (pend) begin
                act = 1; act_start = edge_n; conv_v = pend_v; pend = 0;
            end
            digit = (n / S) % 4;
            m_an  = ~(4'b0001 << digit);
            m_seg = exp_seg(digit, prev);
        end
        #1;
        if (armed) begin
            chk("bcd_out", 32'(dif.bcd_out), 32'(to_bcd(m_val)));
            chk("bcd_valid", 32'(dif.bcd_valid), 32'(m_valid));
            chk("busy", 32'(dif.busy), 32'(act));
            chk("an", 32'(dif.an), 32'(m_an));
            chk("seg", 32'(dif.seg), 32'(m_seg));
            if (!r) chk("an_onehot_low", 32'($countones(~dif.an)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dif.an === target) begin hit = 1; break; end
        end
        chk({name, "_reach"}, 32'(hit), 32'd1);
    endtask

    task automatic convert(input int v, input logic [15:0] exp);
        int cyc;
        bit got;
        dif.dist_valid = 1'b1;
        dif.dist_in    = 12'(v);
        tick();
        dif.dist_valid = 1'b0;
        cyc = 0;
        got = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (dif.bcd_valid === 1'b1) begin got = 1; break; end
        end
        chk("conv_done", 32'(got), 32'd1);
        chk("conv_latency", 32'(cyc), 32'd13);
        chk("conv_value", 32'(dif.bcd_out), 32'(exp));
        $display("convert %0d -> bcd_out=%04h after %0d clocks", v, dif.bcd_out, cyc);
    endtask

    initial begin
        int         pulses;
        logic [15:0] res [2];

        dif.dist_valid = 1'b0;
        dif.dist_in    = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_seg", 32'(dif.seg), 32'h7F);
        chk("rst_an", 32'(dif.an), 32'hF);
        $display("reset: seg=%02h an=%01h", dif.seg, dif.an);
        rst = 1'b0;

        wait_an(4'hE, "idle_d0");
        chk("idle_d0_seg", 32'(dif.seg), 32'h40);
        wait_an(4'hD, "idle_d1");
        chk("idle_d1_seg", 32'(dif.seg), 32'h7F);

        convert(1234, 16'h1234);
        wait_an(4'hE, "d0_1234"); chk("seg_1234_d0", 32'(dif.seg), 32'h19);
        wait_an(4'hD, "d1_1234"); chk("seg_1234_d1", 32'(dif.seg), 32'h30);
        wait_an(4'hB, "d2_1234"); chk("seg_1234_d2", 32'(dif.seg), 32'h24);
        wait_an(4'h7, "d3_1234"); chk("seg_1234_d3", 32'(dif.seg), 32'h79);

        convert(4095, 16'h4095);
        convert(7, 16'h0007);
        wait_an(4'hE, "d0_7"); chk("seg_7_d0", 32'(dif.seg), 32'h78);
        wait_an(4'hD, "d1_7"); chk("seg_7_d1", 32'(dif.seg), 32'h7F);
        wait_an(4'h7, "d3_7"); chk("seg_7_d3", 32'(dif.seg), 32'h7F);

        // Three strobes during a conversion of 50: only 300 survives.
        dif.dist_valid = 1'b1; dif.dist_in = 12'd50;
        tick();
        dif.dist_valid = 1'b0;
        pulses = 0;
        res[0] = '0; res[1] = '0;
        for (int i = 0; i < 45; i++) begin
            if (i == 2) begin dif.dist_valid = 1'b1; dif.dist_in = 12'd100; end
            if (i == 3) dif.dist_in = 12'd200;
            if (i == 4) dif.dist_in = 12'd300;
            if (i == 5) dif.dist_valid = 1'b0;
            tick();
            if (dif.bcd_valid === 1'b1) begin
                if (pulses < 2) res[pulses] = dif.bcd_out;
                pulses++;
                $display("pending test: pulse %0d bcd_out=%04h", pulses, dif.bcd_out);
            end
        end
        dif.dist_valid = 1'b0;
        chk("pend_pulses", 32'(pulses), 32'd2);
        chk("pend_first", 32'(res[0]), 32'h0050);
        chk("pend_second", 32'(res[1]), 32'h0300);

        // Reset while iter==6 of a 999 conversion.
        dif.dist_valid = 1'b1; dif.dist_in = 12'd999;
        tick();
        dif.dist_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dif.bcd_valid === 1'b1) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_bcd", 32'(dif.bcd_out), 32'h0);
        chk("abort_busy", 32'(dif.busy), 32'd0);
        $display("abort: bcd_out=%04h busy=%0b pulses=%0d", dif.bcd_out, dif.busy, pulses);
        convert(999, 16'h0999);

        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
